// File: rtl/replay_buffer_pkg.sv
// Shared definitions for the PCIe data-link-layer replay buffer.
//  - DLLP type encodings carried on ack_nack
//  - replay controller state enum
//  - seq_dist(): modulo distance used to decide how many entries an ACK/NAK retires
package replay_buffer_pkg;

  localparam logic [1:0] DLLP_ACK = 2'b01;
  localparam logic [1:0] DLLP_NAK = 2'b10;

  // Sequence arithmetic is done on a fixed carrier width and masked down to
  // the real sequence width, so one helper serves every SEQ_W below 32.
  localparam int unsigned SEQ_CALC_W = 32;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    REPLAY_WAIT = 2'd1,
    REPLAY      = 2'd2
  } state_e;

  // Number of entries retired by an ACK of seq_ack when the oldest stored
  // entry carries seq_oldest: (seq_ack - seq_oldest + 1) mod 2**seq_w.
  // Zero means the DLLP acknowledges the entry just before the oldest one.
  function automatic logic [SEQ_CALC_W-1:0] seq_dist(
    input logic [SEQ_CALC_W-1:0] seq_ack,
    input logic [SEQ_CALC_W-1:0] seq_oldest,
    input int unsigned           seq_w
  );
    logic [SEQ_CALC_W-1:0] mask;
    mask = (32'd1 << seq_w) - 32'd1;
    return (seq_ack - seq_oldest + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/replay_buffer_mc_serializer.sv
// replay_serializer: splits one DIN_W-bit entry into DIN_W/DOUT_W beats,
// most significant chunk first, under a ready handshake.
// Ports:
//  clk, reset_n   clock / asynchronous active-low reset
//  load           capture din as a new entry (only when idle or on last_take)
//  din            entry payload
//  ready          downstream takes the current beat this cycle
//  dout           current beat (registered, stable while ready=0)
//  dout_valid     dout holds a beat
//  last_take      the final beat of the current entry is taken this cycle
module replay_serializer #(
  parameter int DIN_W  = 128,
  parameter int DOUT_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [DIN_W-1:0]  din,
  input  logic              ready,
  output logic [DOUT_W-1:0] dout,
  output logic              dout_valid,
  output logic              last_take
);

  localparam int BEATS  = DIN_W / DOUT_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [DIN_W-1:0]  shreg_q, shreg_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              valid_q, valid_d;
  logic              take_s;

  assign dout       = shreg_q[DIN_W-1 -: DOUT_W];
  assign dout_valid = valid_q;
  assign last_take  = take_s && (beat_q == BEAT_W'(BEATS - 1));

  // Next beat selection: a load restarts at the MSB chunk, a take shifts up.
  always_comb begin
    shreg_d = shreg_q;
    beat_d  = beat_q;
    valid_d = valid_q;
    take_s  = valid_q && ready;
    if (load) begin
      shreg_d = din;
      beat_d  = {BEAT_W{1'b0}};
      valid_d = 1'b1;
    end else if (last_take) begin
      valid_d = 1'b0;
    end else if (take_s) begin
      shreg_d = shreg_q << DOUT_W;
      beat_d  = beat_q + BEAT_W'(1);
    end else begin
      valid_d = valid_q;
    end
  end

  // Beat state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg_q <= {DIN_W{1'b0}};
      beat_q  <= {BEAT_W{1'b0}};
      valid_q <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/replay_buffer_mc.sv
// replay_buffer_mc: PCIe DLL replay buffer. Stores transmitted TLPs with their
// sequence numbers, retires them on ACK, replays unacknowledged entries on NAK
// or replay timeout, and requests link retrain after REPLAY_MAX replays
// without forward progress.
// Ports:
//  write side : we, din, wr_rdy, tlp_seq
//  DLLP side  : ack_nack (01 ACK, 10 NAK), seq, tim_out
//  read side  : busy_n, ready, dout, dout_valid, replaying
//  status     : retrain, count, ack_err
module replay_buffer_mc
  import replay_buffer_pkg::*;
#(
  parameter int DIN_W      = 128,
  parameter int DOUT_W     = 16,
  parameter int DEPTH      = 8,
  parameter int SEQ_W      = 12,
  parameter int REPLAY_MAX = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       we,
  input  logic [DIN_W-1:0]           din,
  output logic                       wr_rdy,
  output logic [SEQ_W-1:0]           tlp_seq,
  input  logic [1:0]                 ack_nack,
  input  logic [SEQ_W-1:0]           seq,
  input  logic                       tim_out,
  input  logic                       busy_n,
  input  logic                       ready,
  output logic [DOUT_W-1:0]          dout,
  output logic                       dout_valid,
  output logic                       replaying,
  output logic                       retrain,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ack_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = DIN_W + SEQ_W;
  localparam int RN_W  = $clog2(REPLAY_MAX);
  localparam int PAD_S = SEQ_CALC_W - SEQ_W;
  localparam int PAD_C = SEQ_CALC_W - CNT_W;

  state_e                state_q, state_d;
  logic [ENT_W-1:0]      mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rep_ptr_q, rep_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d, rep_left_q, rep_left_d;
  logic [SEQ_W-1:0]      tlp_seq_q, tlp_seq_d;
  logic [RN_W-1:0]       replay_num_q, replay_num_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [1:0]            pend_type_q, pend_type_d;
  logic [SEQ_W-1:0]      pend_seq_q, pend_seq_d;
  logic                  wr_rdy_q, wr_rdy_d;
  logic                  retrain_q, retrain_d;
  logic                  ack_err_q, ack_err_d;
  logic                  replaying_q, replaying_d;

  logic                  dllp_live_s, eff_valid_s, nak_s, purge_s, err_s, wr_fire_s;
  logic                  start_s, load_s, last_take_s;
  logic [1:0]            eff_type_s;
  logic [SEQ_W-1:0]      eff_seq_s, oldest_seq_s;
  logic [SEQ_CALC_W-1:0] dist_s;
  logic [CNT_W-1:0]      cnt_after_s;
  logic [RN_W-1:0]       rn_base_s;
  logic [PTR_W-1:0]      load_idx_s;
  logic [ENT_W-1:0]      load_ent_s;

  assign wr_rdy    = wr_rdy_q;
  assign tlp_seq   = tlp_seq_q;
  assign count     = count_q;
  assign retrain   = retrain_q;
  assign ack_err   = ack_err_q;
  assign replaying = replaying_q;

  assign wr_fire_s   = we && wr_rdy_q;
  assign dllp_live_s = (ack_nack == DLLP_ACK) || (ack_nack == DLLP_NAK);
  // A live DLLP is newer than anything held pending, so it takes precedence.
  assign eff_valid_s = dllp_live_s || pend_valid_q;
  assign eff_type_s  = dllp_live_s ? ack_nack : pend_type_q;
  assign eff_seq_s   = dllp_live_s ? seq : pend_seq_q;
  assign nak_s       = eff_valid_s && (eff_type_s == DLLP_NAK);
  // With an empty buffer the "oldest" entry is the next one to be written,
  // so re-acknowledging the last retired TLP still reads as a duplicate.
  assign oldest_seq_s = (count_q != {CNT_W{1'b0}}) ? mem_q[rd_ptr_q][SEQ_W-1:0] : tlp_seq_q;
  assign dist_s  = seq_dist({{PAD_S{1'b0}}, eff_seq_s}, {{PAD_S{1'b0}}, oldest_seq_s}, SEQ_W);
  assign purge_s = eff_valid_s && (dist_s != {SEQ_CALC_W{1'b0}}) && (dist_s <= {{PAD_C{1'b0}}, count_q});
  assign err_s   = eff_valid_s && (dist_s > {{PAD_C{1'b0}}, count_q});
  assign load_ent_s = mem_q[load_idx_s];

  // Pending DLLP: latch the latest DLLP seen during replay, drop it in IDLE where it is consumed.
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_type_d  = pend_type_q;
    pend_seq_d   = pend_seq_q;
    if (state_q == IDLE) begin
      pend_valid_d = 1'b0;
    end else if (dllp_live_s) begin
      pend_valid_d = 1'b1;
      pend_type_d  = ack_nack;
      pend_seq_d   = seq;
    end else begin
      pend_valid_d = pend_valid_q;
    end
  end

  // Controller next state: purge, write, replay decision and replay sequencing.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    rep_ptr_d    = rep_ptr_q;
    count_d      = count_q;
    rep_left_d   = rep_left_q;
    tlp_seq_d    = tlp_seq_q;
    replay_num_d = replay_num_q;
    retrain_d    = 1'b0;
    ack_err_d    = 1'b0;
    load_s       = 1'b0;
    load_idx_s   = rd_ptr_q;
    cnt_after_s  = count_q;
    rn_base_s    = replay_num_q;
    start_s      = 1'b0;
    case (state_q)
      IDLE: begin
        if (purge_s) begin
          cnt_after_s = count_q - dist_s[CNT_W-1:0];
          rd_ptr_d    = rd_ptr_q + dist_s[PTR_W-1:0];
          rn_base_s   = {RN_W{1'b0}};
        end else begin
          cnt_after_s = count_q;
          rn_base_s   = replay_num_q;
        end
        ack_err_d = err_s;
        // The replay decision sees the post-purge occupancy; a new write is not replayed yet.
        start_s = (nak_s || tim_out) && (cnt_after_s != {CNT_W{1'b0}});
        if (wr_fire_s) begin
          wr_ptr_d  = wr_ptr_q + PTR_W'(1);
          tlp_seq_d = tlp_seq_q + SEQ_W'(1);
          count_d   = cnt_after_s + CNT_W'(1);
        end else begin
          count_d = cnt_after_s;
        end
        if (start_s) begin
          state_d = REPLAY_WAIT;
          if (rn_base_s == RN_W'(REPLAY_MAX - 1)) begin
            retrain_d    = 1'b1;
            replay_num_d = {RN_W{1'b0}};
          end else begin
            replay_num_d = rn_base_s + RN_W'(1);
          end
        end else begin
          replay_num_d = rn_base_s;
        end
      end
      REPLAY_WAIT: begin
        if (busy_n) begin
          state_d    = REPLAY;
          load_s     = 1'b1;
          load_idx_s = rd_ptr_q;
          rep_ptr_d  = rd_ptr_q + PTR_W'(1);
          rep_left_d = count_q - CNT_W'(1);
        end else begin
          state_d = REPLAY_WAIT;
        end
      end
      REPLAY: begin
        if (last_take_s && (rep_left_q != {CNT_W{1'b0}})) begin
          load_s     = 1'b1;
          load_idx_s = rep_ptr_q;
          rep_ptr_d  = rep_ptr_q + PTR_W'(1);
          rep_left_d = rep_left_q - CNT_W'(1);
        end else if (last_take_s) begin
          state_d = IDLE;
        end else begin
          state_d = REPLAY;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    wr_rdy_d    = (count_d < CNT_W'(DEPTH)) && (state_d == IDLE);
    replaying_d = (state_d != IDLE);
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= {PTR_W{1'b0}};
      rd_ptr_q     <= {PTR_W{1'b0}};
      rep_ptr_q    <= {PTR_W{1'b0}};
      count_q      <= {CNT_W{1'b0}};
      rep_left_q   <= {CNT_W{1'b0}};
      tlp_seq_q    <= {SEQ_W{1'b0}};
      replay_num_q <= {RN_W{1'b0}};
      pend_valid_q <= 1'b0;
      pend_type_q  <= 2'b00;
      pend_seq_q   <= {SEQ_W{1'b0}};
      wr_rdy_q     <= 1'b0;
      retrain_q    <= 1'b0;
      ack_err_q    <= 1'b0;
      replaying_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rep_ptr_q    <= rep_ptr_d;
      count_q      <= count_d;
      rep_left_q   <= rep_left_d;
      tlp_seq_q    <= tlp_seq_d;
      replay_num_q <= replay_num_d;
      pend_valid_q <= pend_valid_d;
      pend_type_q  <= pend_type_d;
      pend_seq_q   <= pend_seq_d;
      wr_rdy_q     <= wr_rdy_d;
      retrain_q    <= retrain_d;
      ack_err_q    <= ack_err_d;
      replaying_q  <= replaying_d;
    end
  end

  // Entry storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (wr_fire_s) begin
      mem_q[wr_ptr_q] <= {din, tlp_seq_q};
    end
  end

  replay_serializer #(
    .DIN_W  (DIN_W),
    .DOUT_W (DOUT_W)
  ) u_ser (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load_s),
    .din        (load_ent_s[ENT_W-1:SEQ_W]),
    .ready      (ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .last_take  (last_take_s)
  );

endmodule
